// File: rtl/mem_lane_sequencer.sv
// rtl/mem_lane_sequencer.sv - serialises enabled core lanes onto a single-port memory
module mem_lane_sequencer #(
    parameter int N_CORES    = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      MRead,
    input  logic                      MWrite,
    output logic                      MReady,
    output logic                      done,
    output logic                      err,
    input  logic [N_CORES-1:0]        en,
    input  logic [N_CORES*ADDR_W-1:0] addr,
    input  logic [N_CORES*DATA_W-1:0] data,
    output logic [N_CORES*DATA_W-1:0] q,
    output logic [N_CORES-1:0]        q_valid,
    output logic [ADDR_W-1:0]         addr_mem,
    output logic [DATA_W-1:0]         data_to_mem,
    output logic                      wren,
    input  logic [DATA_W-1:0]         data_from_mem
);

    localparam int LANE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                    state, state_nxt;
    logic [N_CORES-1:0]        pend;
    logic                      op_wr;
    logic [N_CORES*ADDR_W-1:0] addr_lat;
    logic [N_CORES*DATA_W-1:0] data_lat;
    logic [LANE_W-1:0]         lane;
    logic [2:0]                wait_cnt;

    logic                      req_one;
    logic                      req_both;
    logic                      start;
    logic                      last_wait;
    logic [N_CORES-1:0]        pend_rest;
    logic [LANE_W-1:0]         first_lane;
    logic [LANE_W-1:0]         next_lane;

    function automatic logic [LANE_W-1:0] lowest(input logic [N_CORES-1:0] m);
        lowest = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (m[i]) lowest = LANE_W'(i);
        end
    endfunction

    assign req_one    = MRead ^ MWrite;
    assign req_both   = MRead & MWrite;
    assign start      = (state == IDLE) && req_one && (|en);
    assign last_wait  = (wait_cnt == 3'(RD_LATENCY - 1));
    // Lanes still owed after the current one; empty means this lane is the last.
    assign pend_rest  = pend & ~(N_CORES'(1) << lane);
    assign first_lane = lowest(en);
    assign next_lane  = lowest(pend_rest);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE: begin
                if (!op_wr)          state_nxt = WAIT;
                else if (|pend_rest) state_nxt = ISSUE;
                else                 state_nxt = DONE;
            end
            WAIT:    if (last_wait) state_nxt = (|pend_rest) ? ISSUE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            MReady      <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            wren        <= 1'b0;
            q           <= '0;
            q_valid     <= '0;
            addr_mem    <= '0;
            data_to_mem <= '0;
            pend        <= '0;
            op_wr       <= 1'b0;
            addr_lat    <= '0;
            data_lat    <= '0;
            lane        <= '0;
            wait_cnt    <= '0;
        end else begin
            MReady <= (state_nxt == IDLE);
            // An empty-mask request completes immediately without leaving IDLE.
            done   <= (state_nxt == DONE) || ((state == IDLE) && req_one && !(|en));
            err    <= (state == IDLE) && req_both;
            wren   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pend     <= en;
                        op_wr    <= MWrite;
                        addr_lat <= addr;
                        data_lat <= data;
                        lane     <= first_lane;
                        addr_mem <= addr[first_lane*ADDR_W +: ADDR_W];
                        if (MWrite) begin
                            data_to_mem <= data[first_lane*DATA_W +: DATA_W];
                            wren        <= 1'b1;
                        end else begin
                            q_valid <= '0;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    if (op_wr) begin
                        pend <= pend_rest;
                        if (|pend_rest) begin
                            lane        <= next_lane;
                            addr_mem    <= addr_lat[next_lane*ADDR_W +: ADDR_W];
                            data_to_mem <= data_lat[next_lane*DATA_W +: DATA_W];
                            wren        <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (last_wait) begin
                        q[lane*DATA_W +: DATA_W] <= data_from_mem;
                        q_valid[lane]            <= 1'b1;
                        pend                     <= pend_rest;
                        if (|pend_rest) begin
                            lane     <= next_lane;
                            addr_mem <= addr_lat[next_lane*ADDR_W +: ADDR_W];
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lane_sequencer.sv
// tb/tb_mem_lane_sequencer.sv - self-checking bench for mem_lane_sequencer at two read latencies
module tb_mem_lane_sequencer;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        MRead, MWrite;
    logic [3:0]  en;
    logic [63:0] addr, data;

    logic [1:0]  mready, done_s, err_s, wren_s;
    logic [63:0] q_s   [2];
    logic [3:0]  qv_s  [2];
    logic [15:0] am_s  [2];
    logic [15:0] dtm_s [2];
    logic [15:0] dfm   [2];
    logic [15:0] hist  [2][5];

    logic [63:0] mq  [2];
    logic [3:0]  mqv [2];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mem_lane_sequencer #(.N_CORES(4), .ADDR_W(16), .DATA_W(16), .RD_LATENCY(LAT0)) dut0 (
        .clock(clock), .reset_n(reset_n), .MRead(MRead), .MWrite(MWrite),
        .MReady(mready[0]), .done(done_s[0]), .err(err_s[0]),
        .en(en), .addr(addr), .data(data), .q(q_s[0]), .q_valid(qv_s[0]),
        .addr_mem(am_s[0]), .data_to_mem(dtm_s[0]), .wren(wren_s[0]),
        .data_from_mem(dfm[0])
    );

    mem_lane_sequencer #(.N_CORES(4), .ADDR_W(16), .DATA_W(16), .RD_LATENCY(LAT1)) dut1 (
        .clock(clock), .reset_n(reset_n), .MRead(MRead), .MWrite(MWrite),
        .MReady(mready[1]), .done(done_s[1]), .err(err_s[1]),
        .en(en), .addr(addr), .data(data), .q(q_s[1]), .q_valid(qv_s[1]),
        .addr_mem(am_s[1]), .data_to_mem(dtm_s[1]), .wren(wren_s[1]),
        .data_from_mem(dfm[1])
    );

    // Memory returns ~address exactly LAT cycles after it was presented; earlier it
    // still shows data for whatever address was on the bus before.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 4; i > 0; i--) hist[d][i] = hist[d][i-1];
            hist[d][0] = am_s[d];
            dfm[d] = ~hist[d][(d == 0) ? LAT0 : LAT1];
        end
    end

    task automatic do_request(input logic rd, input logic wr, input logic [3:0] e,
                              input logic [63:0] a, input logic [63:0] dt, input string tag);
        int busy[2], done_cnt[2], done_at[2], err_cnt[2], err_at[2], nwr[2];
        logic [15:0] wa[2][8];
        logic [15:0] wd[2][8];
        int wc[2][8];
        int k, lat, j;
        int exp_busy, exp_done, exp_err, exp_nwr;
        for (int d = 0; d < 2; d++) begin
            busy[d] = 0; done_cnt[d] = 0; done_at[d] = 0;
            err_cnt[d] = 0; err_at[d] = 0; nwr[d] = 0;
        end
        @(negedge clock);
        MRead = rd; MWrite = wr; en = e; addr = a; data = dt;
        @(posedge clock);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                if (!mready[d]) busy[d]++;
                if (done_s[d]) begin done_cnt[d]++; done_at[d] = cyc; end
                if (err_s[d]) begin err_cnt[d]++; err_at[d] = cyc; end
                if (wren_s[d]) begin
                    if (nwr[d] < 8) begin
                        wa[d][nwr[d]] = am_s[d];
                        wd[d][nwr[d]] = dtm_s[d];
                        wc[d][nwr[d]] = cyc;
                    end
                    nwr[d]++;
                end
            end
            MRead = 1'b0; MWrite = 1'b0;
            en = 4'($urandom);
            addr = {$urandom, $urandom};
            data = {$urandom, $urandom};
        end
        k = $countones(e);
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? LAT0 : LAT1;
            exp_busy = 0; exp_done = 0; exp_err = 0; exp_nwr = 0;
            if (rd && wr) exp_err = 1;
            else if (rd || wr) begin
                exp_done = 1;
                if (e != 0) exp_busy = wr ? k + 1 : k * (1 + lat) + 1;
                if (wr) exp_nwr = k;
            end
            checks++;
            if (busy[d] !== exp_busy) begin
                failures++;
                $display("FAIL %s dut%0d busy_cycles: got %0d expected %0d", tag, d, busy[d], exp_busy);
            end
            checks++;
            if (done_cnt[d] !== exp_done) begin
                failures++;
                $display("FAIL %s dut%0d done_count: got %0d expected %0d", tag, d, done_cnt[d], exp_done);
            end
            if (exp_done == 1) begin
                checks++;
                if (done_at[d] !== ((exp_busy == 0) ? 1 : exp_busy)) begin
                    failures++;
                    $display("FAIL %s dut%0d done_cycle: got %0d expected %0d", tag, d, done_at[d],
                             (exp_busy == 0) ? 1 : exp_busy);
                end
            end
            checks++;
            if (err_cnt[d] !== exp_err || (exp_err == 1 && err_at[d] !== 1)) begin
                failures++;
                $display("FAIL %s dut%0d err_pulse: got count %0d at %0d expected count %0d at 1",
                         tag, d, err_cnt[d], err_at[d], exp_err);
            end
            checks++;
            if (nwr[d] !== exp_nwr) begin
                failures++;
                $display("FAIL %s dut%0d write_count: got %0d expected %0d", tag, d, nwr[d], exp_nwr);
            end
            j = 0;
            if (exp_nwr > 0) begin
                for (int i = 0; i < 4; i++) begin
                    if (e[i]) begin
                        if (j < nwr[d] && j < 8) begin
                            checks++;
                            if (wa[d][j] !== a[i*16 +: 16] || wd[d][j] !== dt[i*16 +: 16] || wc[d][j] !== j + 1) begin
                                failures++;
                                $display("FAIL %s dut%0d write%0d: got a=%h d=%h c=%0d expected a=%h d=%h c=%0d",
                                         tag, d, j, wa[d][j], wd[d][j], wc[d][j], a[i*16 +: 16], dt[i*16 +: 16], j + 1);
                            end
                        end
                        j++;
                    end
                end
            end
            if (rd && !wr && e != 0) begin
                mqv[d] = e;
                for (int i = 0; i < 4; i++)
                    if (e[i]) mq[d][i*16 +: 16] = ~a[i*16 +: 16];
            end
            checks++;
            if (qv_s[d] !== mqv[d] || q_s[d] !== mq[d]) begin
                failures++;
                $display("FAIL %s dut%0d q: got qv=%b q=%h expected qv=%b q=%h", tag, d, qv_s[d], q_s[d], mqv[d], mq[d]);
            end
            checks++;
            if (mready[d] !== 1'b1) begin
                failures++;
                $display("FAIL %s dut%0d final_mready: got %b expected 1", tag, d, mready[d]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; MRead = 1'b0; MWrite = 1'b0; en = '0; addr = '0; data = '0;
        for (int d = 0; d < 2; d++) begin mq[d] = '0; mqv[d] = '0; end
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (mready[d] !== 1'b1 || done_s[d] !== 1'b0 || err_s[d] !== 1'b0 || wren_s[d] !== 1'b0 ||
                qv_s[d] !== 4'b0 || q_s[d] !== 64'b0 || am_s[d] !== 16'b0 || dtm_s[d] !== 16'b0) begin
                failures++;
                $display("FAIL reset dut%0d: got rdy=%b done=%b err=%b wren=%b qv=%b q=%h am=%h dtm=%h expected 1,0,0,0,0,0,0,0",
                         d, mready[d], done_s[d], err_s[d], wren_s[d], qv_s[d], q_s[d], am_s[d], dtm_s[d]);
            end
        end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (mready !== 2'b11) begin
            failures++;
            $display("FAIL reset_release mready: got %b expected 11", mready);
        end
    endtask

    task automatic test_write_all();
        do_request(1'b0, 1'b1, 4'b1111, {16'h0013, 16'h0012, 16'h0011, 16'h0010},
                   {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, "write_all");
    endtask

    task automatic test_read_sparse();
        do_request(1'b1, 1'b0, 4'b1010, {$urandom, $urandom}, {$urandom, $urandom}, "read_sparse");
    endtask

    task automatic test_read_single();
        do_request(1'b1, 1'b0, 4'b0001, {$urandom, $urandom}, {$urandom, $urandom}, "read_single");
    endtask

    task automatic test_err();
        do_request(1'b1, 1'b1, 4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, "both_strobes");
    endtask

    task automatic test_empty_mask();
        do_request(1'b0, 1'b1, 4'b0000, {$urandom, $urandom}, {$urandom, $urandom}, "empty_mask");
    endtask

    task automatic test_random();
        logic [1:0] op;
        for (int n = 0; n < 30; n++) begin
            op = 2'($urandom_range(0, 3));
            do_request(op[0], op[1], 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, "random");
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        MWrite = 1'b1; MRead = 1'b0; en = 4'b1111;
        addr = {$urandom, $urandom}; data = {$urandom, $urandom};
        @(posedge clock);
        @(negedge clock);
        MWrite = 1'b0;
        @(negedge clock);
        checks++;
        if (wren_s !== 2'b11) begin
            failures++;
            $display("FAIL reset_mid wren_before: got %b expected 11", wren_s);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (wren_s !== 2'b00 || mready !== 2'b11) begin
            failures++;
            $display("FAIL reset_mid async_drop: got wren=%b rdy=%b expected wren=00 rdy=11", wren_s, mready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int d = 0; d < 2; d++) begin mq[d] = '0; mqv[d] = '0; end
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (mready[d] !== 1'b1 || qv_s[d] !== 4'b0 || wren_s[d] !== 1'b0 || done_s[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid after dut%0d: got rdy=%b qv=%b wren=%b done=%b expected 1,0,0,0",
                         d, mready[d], qv_s[d], wren_s[d], done_s[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_all();
        test_read_sparse();
        test_read_single();
        test_err();
        test_empty_mask();
        test_random();
        test_reset_mid();
        test_read_sparse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
